// File: rtl/seq_multiplier_pkg.sv
// ----------------------------------------------------------------------------
// seq_multiplier_pkg
//
// Shared constants for the RISC240 datapath multiplier.
//   WORD_WIDTH  : machine word width, used as the default operand width
//   mul_state_t : multiplier sequencing states (idle, iterating, result held)
//   countWidth  : bit width of an iteration counter that reaches width-1
// ----------------------------------------------------------------------------
package seq_multiplier_pkg;

   localparam int WORD_WIDTH = 16;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_t;

   // A one-bit counter is still needed when only one iteration is run
   function automatic int countWidth(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/seq_multiplier.sv
// ----------------------------------------------------------------------------
// seq_multiplier
//
// Iterative shift-add unsigned multiplier. One partial product is added per
// clock, so a WIDTH-bit multiply takes exactly WIDTH cycles after acceptance.
// The controlpath holds start high until mulDone and then drops it.
//
// Ports:
//   clock    : system clock, rising edge active
//   reset_L  : asynchronous active-low reset
//   start    : level request, held high until mulDone is seen
//   opA      : multiplicand, sampled only on the accepting edge
//   opB      : multiplier, sampled only on the accepting edge
//   product  : last completed 2*WIDTH-bit product (registered)
//   mulDone  : high while the completed result is being held
//   busy     : high while iterations are in progress
// ----------------------------------------------------------------------------
module seq_multiplier
   import seq_multiplier_pkg::*;
#(
   parameter int WIDTH = WORD_WIDTH
) (
   input  logic               clock,
   input  logic               reset_L,
   input  logic               start,
   input  logic [WIDTH-1:0]   opA,
   input  logic [WIDTH-1:0]   opB,
   output logic [2*WIDTH-1:0] product,
   output logic               mulDone,
   output logic               busy
);

   localparam int CNT_W = countWidth(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   mul_state_t           state_q,   state_d;
   logic [2*WIDTH-1:0]   acc_q,     acc_d;
   logic [2*WIDTH-1:0]   mcand_q,   mcand_d;
   logic [WIDTH-1:0]     mplier_q,  mplier_d;
   logic [CNT_W-1:0]     count_q,   count_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic [2*WIDTH-1:0]   partialSum;

   // The accumulator plus the current partial product. The multiplicand has
   // been shifted at most WIDTH-1 places, so this sum never exceeds 2*WIDTH
   // bits and no carry out is lost.
   always_comb begin
      partialSum = acc_q + (mplier_q[0] ? mcand_q : '0);
   end

   // Next-state logic. Abort has priority over iterating: if the
   // controlpath drops start mid-run, the partial result is thrown away and
   // product keeps whatever the last completed run produced. The final
   // iteration writes product directly from partialSum so that the last
   // add is included without an extra cycle.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      count_d   = count_q;
      product_d = product_q;

      unique case (state_q)
         MUL_IDLE: begin
            if (start) begin
               mcand_d  = {{WIDTH{1'b0}}, opA};
               mplier_d = opB;
               acc_d    = '0;
               count_d  = '0;
               state_d  = MUL_RUN;
            end
         end

         MUL_RUN: begin
            if (!start) begin
               state_d = MUL_IDLE;
            end else begin
               acc_d    = partialSum;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               count_d  = count_q + CNT_W'(1);
               if (count_q == LAST_ITER) begin
                  product_d = partialSum;
                  state_d   = MUL_DONE;
               end
            end
         end

         MUL_DONE: begin
            // Requiring start to go low before leaving prevents a held
            // request from immediately retriggering another multiply.
            if (!start) begin
               state_d = MUL_IDLE;
            end
         end

         default: begin
            state_d = MUL_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any run in progress.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_q   <= MUL_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   assign product = product_q;
   assign busy    = (state_q == MUL_RUN);
   assign mulDone = (state_q == MUL_DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// ----------------------------------------------------------------------------
// tb_seq_multiplier
//
// Directed and randomized checks of seq_multiplier. Expected products come
// from plain integer multiplication; expected timing comes from the
// documented handshake (result WIDTH edges after the accepting edge).
// ----------------------------------------------------------------------------
module tb_seq_multiplier;

   localparam int W = 16;

   logic           clock;
   logic           reset_L;
   logic           start;
   logic [W-1:0]   opA;
   logic [W-1:0]   opB;
   logic [2*W-1:0] product;
   logic           mulDone;
   logic           busy;

   int testsRun    = 0;
   int testsFailed = 0;

   seq_multiplier #(.WIDTH(W)) dut (
      .clock   (clock),
      .reset_L (reset_L),
      .start   (start),
      .opA     (opA),
      .opB     (opB),
      .product (product),
      .mulDone (mulDone),
      .busy    (busy)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference model: the product is simply the integer product of the
   // two operands, evaluated in 2*W-bit unsigned arithmetic.
   function automatic logic [2*W-1:0] expectedProduct(input logic [W-1:0] a,
                                                      input logic [W-1:0] b);
      logic [2*W-1:0] wa;
      logic [2*W-1:0] wb;
      wa = {{W{1'b0}}, a};
      wb = {{W{1'b0}}, b};
      return wa * wb;
   endfunction

   // One comparison: counts it, and on mismatch counts and reports it.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Present a request; it is accepted on the next rising edge.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
      opA   = a;
      opB   = b;
      start = 1'b1;
   endtask

   // Advance to just after the next rising edge, a safe sampling point.
   task automatic stepEdge();
      @(posedge clock);
      #1;
   endtask

   // Issue a multiply and wait (bounded) for mulDone; checks latency,
   // busy duration and the product. Start stays high on return.
   task automatic runToDone(input string tag, input logic [W-1:0] a,
                            input logic [W-1:0] b, input bit scramble);
      int edges;
      int busyCycles;
      applyStimulus(a, b);
      stepEdge();
      checkOutput({tag, "_busyAtAccept"}, 64'(busy), 64'd1);
      edges      = 0;
      busyCycles = 0;
      while (!mulDone && edges < 40) begin
         if (busy) busyCycles++;
         if (scramble && edges == 1) begin
            opA = 16'hAAAA;
            opB = 16'hAAAA;
         end
         stepEdge();
         edges++;
      end
      checkOutput({tag, "_latency"}, 64'(edges), 64'(W));
      checkOutput({tag, "_busyCycles"}, 64'(busyCycles), 64'(W));
      checkOutput({tag, "_busyAtDone"}, 64'(busy), 64'd0);
      checkOutput({tag, "_product"}, 64'(product), 64'(expectedProduct(a, b)));
   endtask

   // Drop start after completion; mulDone must fall on the next edge.
   task automatic releaseStart(input string tag);
      start = 1'b0;
      stepEdge();
      checkOutput({tag, "_doneFalls"}, 64'(mulDone), 64'd0);
   endtask

   initial begin
      logic [W-1:0]   ra;
      logic [W-1:0]   rb;
      logic [2*W-1:0] held;

      reset_L = 1'b0;
      start   = 1'b0;
      opA     = '0;
      opB     = '0;

      // Reset state
      #12;
      checkOutput("reset_product", 64'(product), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_mulDone", 64'(mulDone), 64'd0);
      reset_L = 1'b1;
      stepEdge();

      // Basic, then hold start past mulDone and check the result is held
      runToDone("basic", 16'h0003, 16'h0005, 1'b0);
      for (int i = 0; i < 3; i++) begin
         stepEdge();
         checkOutput("hold_mulDone", 64'(mulDone), 64'd1);
         checkOutput("hold_product", 64'(product), 64'h0000000F);
      end
      releaseStart("basic");

      // Reassert for a fresh run after start was low for an edge
      runToDone("rerun", 16'h0100, 16'h0100, 1'b0);
      releaseStart("rerun");

      runToDone("max", 16'hFFFF, 16'hFFFF, 1'b0);
      checkOutput("max_constant", 64'(product), 64'hFFFE0001);
      releaseStart("max");

      runToDone("zero", 16'h0000, 16'h1234, 1'b0);
      releaseStart("zero");

      // Operands change after acceptance; result must follow the latched ones
      runToDone("isolate", 16'h1357, 16'h2468, 1'b0 | 1'b1);
      releaseStart("isolate");

      // Abort: complete 7*9, then drop start during a 0x1234*0x0010 run
      runToDone("pre_abort", 16'h0007, 16'h0009, 1'b0);
      releaseStart("pre_abort");
      applyStimulus(16'h1234, 16'h0010);
      stepEdge();
      for (int i = 0; i < 5; i++) stepEdge();
      start = 1'b0;
      stepEdge();
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_product", 64'(product), 64'h0000003F);
      for (int i = 0; i < 20; i++) begin
         stepEdge();
         checkOutput("abort_noDone", 64'(mulDone), 64'd0);
      end
      checkOutput("abort_productHeld", 64'(product), 64'h0000003F);

      // Reset between edges in the middle of a run
      applyStimulus(16'h5555, 16'h3333);
      stepEdge();
      for (int i = 0; i < 3; i++) stepEdge();
      checkOutput("midrun_busy", 64'(busy), 64'd1);
      #2;
      reset_L = 1'b0;
      start   = 1'b0;
      #1;
      checkOutput("midreset_product", 64'(product), 64'd0);
      checkOutput("midreset_busy", 64'(busy), 64'd0);
      checkOutput("midreset_mulDone", 64'(mulDone), 64'd0);
      #3;
      reset_L = 1'b1;
      stepEdge();
      runToDone("postreset", 16'h0002, 16'h0003, 1'b0);
      checkOutput("postreset_constant", 64'(product), 64'h00000006);
      releaseStart("postreset");

      // Randomized operands against the reference model
      for (int i = 0; i < 10; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         runToDone("random", ra, rb, 1'b0);
         releaseStart("random");
         held = expectedProduct(ra, rb);
         stepEdge();
         checkOutput("random_heldInIdle", 64'(product), 64'(held));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
